piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in/serial-out transmitter: the sending end for the team's 4-bit bidirectional shift-register receiver (`bidirectional_shift_register`).
- Accepts a WIDTH-bit word over a valid/ready handshake, then emits it one bit per enabled cycle, LSB-first or MSB-first.
- Drives serial_out/serial_valid straight into the receiver's serial_in/shift_en, so the receiver's q equals the loaded word once the word is complete.

Parameters:
- WIDTH, 4, data word width in bits; legal values are 2 and above.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  parallel word offered.
- load_ready  out  1  transmitter can accept a word.
- load_data  in  WIDTH  word to send.
- dir  in  1  0 = LSB first (pairs with receiver dir=0, right shift); 1 = MSB first (pairs with receiver dir=1).
- shift_en  in  1  permits one bit to advance this cycle (stall when low).
- serial_out  out  1  current serial bit.
- serial_valid  out  1  serial_out carries a bit that is consumed this cycle.
- busy  out  1  word in flight.
- done  out  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- States: IDLE, SHIFT (plus PARITY when the optional feature is built). Encoded as an enum.
- Reset (rst=1 at a clock edge):
  - state = IDLE, sreg = 0, cnt = 0, dir_q = 0, done = 0.
  - While rst is high, load_ready = 0, serial_valid = 0 and serial_out = 0.
  - Reset mid-word abandons the word: no done pulse, and IDLE is reached the next cycle.
- Handshake:
  - load_ready = (state == IDLE) && !rst.
  - A transfer occurs when load_valid && load_ready at the clock edge: sreg <= load_data, dir_q <= dir, cnt <= 0, state <= SHIFT.
  - load_valid outside IDLE is ignored; load_data must not be captured then.
- SHIFT:
  - serial_out = dir_q ? sreg[WIDTH-1] : sreg[0], driven combinationally from registers.
  - serial_valid = shift_en.
  - On shift_en=1: sreg shifts toward the output end (right if dir_q=0, left if dir_q=1), zero-filled; cnt++.
  - When cnt == WIDTH-1 and shift_en=1: next state is IDLE, and done = 1 in the following cycle only.
  - shift_en=0: sreg and cnt hold; serial_out stays stable.
- Latency: first bit is visible the cycle after acceptance. With shift_en held high, the word takes exactly WIDTH cycles, plus one mandatory IDLE cycle before the next accept (throughput = 1 word per WIDTH+1 cycles).
- A dir change after acceptance has no effect on the word in flight.
- busy = (state != IDLE).
- In IDLE, serial_out = 0 and serial_valid = 0.

Optional Feature:
- Macro: PISO_SHIFT_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY and sends one extra bit: the even parity (XOR) of the accepted word, latched at load.
  - The PARITY bit is consumed on shift_en=1, then done pulses. A word is WIDTH+1 bits.
- Undefined: the PARITY state and parity register are absent; exactly WIDTH bits per word.

Decomposition:
- Package piso_shift_tx_pkg holds:
  - state enum typedef (ST_IDLE, ST_SHIFT, ST_PARITY);
  - DIR_LSB_FIRST = 1'b0 and DIR_MSB_FIRST = 1'b1;
  - default WIDTH constant.
- One natural sub-module: piso_bit_counter.
  - Inputs: clr, en.
  - Outputs: count, last (asserted when count == WIDTH-1).
- The FSM and shift register stay in the top module.

Test Plan (WIDTH=4, macro undefined unless stated):
- Reset: rst high for 2 cycles with load_valid=1 -> load_ready=0, serial_valid=0, done=0, no word captured. After release, load_ready=1 and busy=0.
- dir=0, load 4'b1011, shift_en=1 -> serial_out 1,1,0,1 on four consecutive serial_valid cycles. done pulses one cycle later; load_ready is high that cycle. Loopback into the receiver (dir=0) yields q=1011.
- dir=1, load 4'b1011 -> serial_out 1,0,1,1. Receiver (dir=1) loopback gives q=1011.
- Stall: load 4'b0110 with dir=0; drop shift_en for 3 cycles after the first bit -> serial_out held at 1, serial_valid=0 while stalled. Exactly 4 valid bits (0,1,1,0) are sent; done appears once.
- Mid-word events: during SHIFT, present load_valid=1 with 4'b1111 and toggle dir -> ignored, and the original word completes unchanged. Then assert rst after 2 bits -> IDLE next cycle, no done, and a fresh load sends correctly.
- Macro defined: load 4'b1011, dir=0 -> serial_out 1,1,0,1 then parity 1. done follows the 5th bit. With 4'b1001 the parity bit is 0.

Source files
------------

// File: rtl/piso_shift_tx_pkg.sv
// piso_shift_tx shared types and constants.
// FSM state encoding, shift-direction codes and the default word width.
package piso_shift_tx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for piso_shift_tx.
// Counts consumed bits; last flags the final data bit of a word.
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clear wins over increment so a fresh word always starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter, LSB- or MSB-first.
// Define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit per word.
module piso_shift_tx
  import piso_shift_tx_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             dir_q;
  logic             dir_d;
  logic             done_q;
  logic             done_d;
  logic             accept;
  logic             cnt_en;
  logic             cnt_last;
  logic             in_word;
  logic [CNT_W-1:0] cnt;
`ifdef PISO_SHIFT_TX_PARITY_EN
  logic             par_q;
  logic             par_d;
`endif

  assign load_ready = (state_q == ST_IDLE) && !rst;
  assign accept     = load_valid && load_ready;
  assign in_word    = (cnt < CNT_W'(WIDTH));
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

  // next state, shift datapath and serial outputs
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    dir_d        = dir_q;
    done_d       = 1'b0;
    cnt_en       = 1'b0;
    serial_out   = 1'b0;
    serial_valid = 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
    par_d        = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sreg_d  = load_data;
          dir_d   = dir;
          state_d = ST_SHIFT;
`ifdef PISO_SHIFT_TX_PARITY_EN
          par_d   = ^load_data;
`endif
        end
      end
      ST_SHIFT: begin
        serial_out   = (dir_q == DIR_MSB_FIRST) ?
                       sreg_q[WIDTH-1] : sreg_q[0];
        serial_valid = shift_en && in_word;
        if (serial_valid) begin
          cnt_en = 1'b1;
          sreg_d = (dir_q == DIR_MSB_FIRST) ?
                   {sreg_q[WIDTH-2:0], 1'b0} :
                   {1'b0, sreg_q[WIDTH-1:1]};
          if (cnt_last) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_SHIFT_TX_PARITY_EN
      ST_PARITY: begin
        serial_out   = par_q;
        serial_valid = shift_en;
        if (shift_en) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // reset silences the serial side immediately
    if (rst) begin
      serial_out   = 1'b0;
      serial_valid = 1'b0;
    end
  end

  // state, shift register, captured direction and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      dir_q   <= DIR_LSB_FIRST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

`ifdef PISO_SHIFT_TX_PARITY_EN
  // parity of the accepted word, sent after the data bits
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx.
// Table vectors, corner sequences and random words vs a bit-order model.
module tb_piso_shift_tx;
  import piso_shift_tx_pkg::*;

  localparam int W = 4;
`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         dir;
  logic         shift_en;
  logic         serial_out;
  logic         serial_valid;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .dir          (dir),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         d;
    int           mode;
    bit           noise;
    logic [W-1:0] exp_seq;
    logic         exp_par;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bit i of the result is the i-th bit on the wire
  function automatic logic [NB-1:0] model_seq(input logic [W-1:0] w,
                                              input logic d);
    logic [NB-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++) s[i] = d ? w[W-1-i] : w[i];
`ifdef PISO_SHIFT_TX_PARITY_EN
    s[W] = ^w;
`endif
    return s;
  endfunction

  // mode 0: shift_en high; 1: 3-cycle stall after first bit; 2: random
  task automatic send_word(input logic [W-1:0] w, input logic d,
                           input int mode, input bit noise,
                           input logic [NB-1:0] exp, input string tag);
    logic [NB-1:0] got;
    logic [W-1:0]  rx;
    int            idx;
    int            waitc;
    bit            fin;
    got = '0;
    rx  = '0;
    idx = 0;
    fin = 1'b0;
    load_valid = 1'b1;
    load_data  = w;
    dir        = d;
    shift_en   = 1'b0;
    #1;
    waitc = 0;
    while (!load_ready && waitc < 10) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({tag, "_ready"}, load_ready, 1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      case (mode)
        0:       shift_en = 1'b1;
        1:       shift_en = !(cyc >= 1 && cyc <= 3);
        default: shift_en = ($urandom_range(0, 3) != 0);
      endcase
      if (noise && idx < NB) begin
        load_valid = 1'b1;
        load_data  = '1;
        dir        = ~dir;
      end else begin
        load_valid = 1'b0;
      end
      #1;
      if (idx < NB) begin
        chk({tag, "_cyc"},
            {serial_out, serial_valid, busy, load_ready, done},
            {exp[idx], shift_en, 1'b1, 1'b0, 1'b0});
        if (shift_en) begin
          got[idx] = serial_out;
          if (idx < W)
            rx = d ? {rx[W-2:0], serial_out} : {serial_out, rx[W-1:1]};
          idx++;
        end
      end else begin
        chk({tag, "_done"},
            {done, load_ready, busy, serial_valid, serial_out}, 5'b11000);
        if (mode == 0) chk({tag, "_lat"}, cyc, NB);
        if (mode == 1) chk({tag, "_lat"}, cyc, NB + 3);
        fin = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!fin) chk({tag, "_timeout"}, 0, 1);
    load_valid = 1'b0;
    shift_en   = 1'b0;
    #1;
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_seq"}, got, exp);
    chk({tag, "_rx"}, rx, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] e;
    logic [W-1:0]  w;
    logic          d;

    tbl[0] = '{4'b1011, 1'b0, 0, 1'b0, 4'b1011, 1'b1};
    tbl[1] = '{4'b1011, 1'b1, 0, 1'b0, 4'b1101, 1'b1};
    tbl[2] = '{4'b0110, 1'b0, 1, 1'b0, 4'b0110, 1'b0};
    tbl[3] = '{4'b1011, 1'b0, 0, 1'b1, 4'b1011, 1'b1};
    tbl[4] = '{4'b1001, 1'b0, 0, 1'b0, 4'b1001, 1'b0};
    tbl[5] = '{4'b1001, 1'b1, 2, 1'b0, 4'b1001, 1'b0};

    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = '1;
    dir        = 1'b0;
    shift_en   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_hold", {load_ready, serial_valid, serial_out, done}, 4'b0000);
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("rst_release", {load_ready, busy, serial_valid, serial_out}, 4'b1000);

    for (int i = 0; i < 6; i++) begin
      e = NB'(tbl[i].exp_seq);
`ifdef PISO_SHIFT_TX_PARITY_EN
      e[W] = tbl[i].exp_par;
`endif
      send_word(tbl[i].data, tbl[i].d, tbl[i].mode, tbl[i].noise, e,
                $sformatf("vec%0d", i));
    end

    load_valid = 1'b1;
    load_data  = 4'b1011;
    dir        = 1'b0;
    shift_en   = 1'b0;
    #1;
    chk("mrst_ready", load_ready, 1);
    @(posedge clk); #1;
    load_valid = 1'b0;
    shift_en   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_hold", {load_ready, serial_valid, serial_out}, 3'b000);
    @(posedge clk); #1;
    rst      = 1'b0;
    shift_en = 1'b0;
    #1;
    chk("mrst_idle", {busy, done, load_ready}, 3'b001);
    @(posedge clk); #1;
    chk("mrst_nodone", done, 0);
    send_word(4'b0110, 1'b1, 0, 1'b0, model_seq(4'b0110, 1'b1), "fresh");

    for (int i = 0; i < 20; i++) begin
      w = W'($urandom);
      d = 1'($urandom);
      send_word(w, d, 2, 1'($urandom_range(0, 1)), model_seq(w, d),
                $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
